// File: rtl/disp_bcd_conv.sv
// disp_bcd_conv: converts a 16-bit frequency value and a 16-bit peak-to-peak
// value into five BCD digits each. One shared double-dabble datapath
// handles the frequency first and then the voltage. Both results are
// presented together with a one-cycle odone pulse.
module disp_bcd_conv #(
   parameter bit BLANK_LZ = 1'b0
) (
   input  logic        iclk,
   input  logic        irst,
   input  logic        istart,
   input  logic [15:0] ifrq,
   input  logic [15:0] ivpp,
   output logic        obusy,
   output logic        odone,
   output logic [19:0] ofrq_bcd,
   output logic [19:0] ovpp_bcd
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FRQ  = 2'd1,
      VPP  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [15:0] vpp_hold_r;   // ivpp captured at accept, converted second
   logic [19:0] bcd_r;        // shared BCD scratch
   logic [15:0] bin_r;        // shared binary shift register
   logic [4:0]  cnt_r;        // step counter, 0..15 within a channel
   logic [19:0] frq_res_r;    // finished frequency digits, parked until DONE
   logic [35:0] step_s;       // {bcd, bin} after one double-dabble step
   logic        last_step_s;

   // One double-dabble step: add 3 to every digit >= 5, then shift
   // {bcd, bin} left by one so the binary MSB enters the BCD ones digit.
   function automatic logic [35:0] dd_step(input logic [19:0] bcd,
                                           input logic [15:0] bin);
      logic [19:0] adj;
      adj = bcd;
      for (int i = 0; i < 5; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) begin
            adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
         end else begin
            adj[i*4 +: 4] = bcd[i*4 +: 4];
         end
      end
      return {adj[18:0], bin, 1'b0};
   endfunction

   // Replace zero digits above the most significant non-zero digit by 4'hF.
   // The ones digit always stays visible.
   function automatic logic [19:0] blank_lz(input logic [19:0] d);
      logic [19:0] res;
      logic        lead;
      res  = d;
      lead = 1'b1;
      for (int i = 4; i >= 1; i--) begin
         if (lead && (d[i*4 +: 4] == 4'd0)) begin
            res[i*4 +: 4] = 4'hF;
         end else begin
            lead = 1'b0;
         end
      end
      return res;
   endfunction

   // Next-state logic and the combinational converter step.
   always_comb begin
      state_nxt_s = state_r;
      step_s      = dd_step(bcd_r, bin_r);
      last_step_s = (cnt_r == 5'd15);
      case (state_r)
         IDLE: begin
            if (istart) begin
               state_nxt_s = FRQ;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         FRQ: begin
            if (last_step_s) begin
               state_nxt_s = VPP;
            end else begin
               state_nxt_s = FRQ;
            end
         end
         VPP: begin
            if (last_step_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = VPP;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge iclk) begin
      if (irst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Shared converter datapath: capture on accept, then 16 steps per channel.
   always_ff @(posedge iclk) begin
      if (irst) begin
         vpp_hold_r <= 16'd0;
         bcd_r      <= 20'd0;
         bin_r      <= 16'd0;
         cnt_r      <= 5'd0;
         frq_res_r  <= 20'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (istart) begin
                  bin_r      <= ifrq;
                  vpp_hold_r <= ivpp;
                  bcd_r      <= 20'd0;
                  cnt_r      <= 5'd0;
               end else begin
                  cnt_r      <= cnt_r;
               end
            end
            FRQ: begin
               if (last_step_s) begin
                  // Park the frequency digits and reload the datapath with ivpp.
                  frq_res_r <= step_s[35:16];
                  bcd_r     <= 20'd0;
                  bin_r     <= vpp_hold_r;
                  cnt_r     <= 5'd0;
               end else begin
                  bcd_r     <= step_s[35:16];
                  bin_r     <= step_s[15:0];
                  cnt_r     <= cnt_r + 5'd1;
               end
            end
            VPP: begin
               bcd_r <= step_s[35:16];
               bin_r <= step_s[15:0];
               if (last_step_s) begin
                  cnt_r <= 5'd0;
               end else begin
                  cnt_r <= cnt_r + 5'd1;
               end
            end
            DONE: begin
               cnt_r <= 5'd0;
            end
            default: begin
               cnt_r <= 5'd0;
            end
         endcase
      end
   end

   // Registered outputs: busy flag, done pulse and both digit sets loaded together.
   always_ff @(posedge iclk) begin
      if (irst) begin
         obusy    <= 1'b0;
         odone    <= 1'b0;
         ofrq_bcd <= 20'd0;
         ovpp_bcd <= 20'd0;
      end else begin
         obusy <= (state_nxt_s != IDLE);
         if (state_r == DONE) begin
            odone    <= 1'b1;
            ofrq_bcd <= BLANK_LZ ? blank_lz(frq_res_r) : frq_res_r;
            ovpp_bcd <= BLANK_LZ ? blank_lz(bcd_r)     : bcd_r;
         end else begin
            odone    <= 1'b0;
         end
      end
   end

endmodule

// File: doc/disp_bcd_conv.md
DISP_BCD_CONV -- requirements
Module: disp_bcd_conv

Interface
REQ-001 SHALL provide parameter BLANK_LZ, default 0; when 1, leading-zero digits are replaced by 4'hF for display blanking.
REQ-002 SHALL provide port iclk, input, 1, system clock; the DDS PLL clock that also drives the OLED driver.
REQ-003 SHALL provide port irst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL provide port istart, input, 1, conversion request, sampled on each rising edge.
REQ-005 SHALL provide port ifrq, input, 16, binary display frequency value.
REQ-006 SHALL provide port ivpp, input, 16, binary peak-to-peak value in mV.
REQ-007 SHALL provide port obusy, output, 1, high while a conversion is in progress.
REQ-008 SHALL provide port odone, output, 1, one-cycle pulse when new results are presented.
REQ-009 SHALL provide port ofrq_bcd, output, 20, five BCD digits of ifrq; [3:0] is the ones digit.
REQ-010 SHALL provide port ovpp_bcd, output, 20, five BCD digits of ivpp; [3:0] is the ones digit.

Function
REQ-011 SHALL use single clock iclk only; all state and outputs are registered, with no combinational input-to-output path.
REQ-012 SHALL implement states IDLE, FRQ, VPP, DONE; obusy = (state != IDLE), registered-equivalent.
REQ-013 SHALL, on an edge with state IDLE and istart=1 (accept edge t0), latch ifrq and ivpp into internal registers, clear the BCD scratch register and bit counter, and move to FRQ.
REQ-014 SHALL ignore istart in FRQ, VPP and DONE; a request arriving in these states is neither queued nor remembered.
REQ-015 SHALL ignore changes on ifrq/ivpp after t0 for the conversion in progress.
REQ-016 SHALL perform one double-dabble step per edge in FRQ: every BCD digit >= 5 gets +3, then a 1-bit left shift of {bcd, binary}, MSB first; exactly 16 steps (edges t1..t16), then move to VPP.
REQ-017 SHALL store the FRQ result internally and convert ivpp identically in VPP over exactly 16 steps (edges t17..t32), then move to DONE.
REQ-018 SHALL, on the DONE edge t33, load ofrq_bcd and ovpp_bcd simultaneously, set odone=1 for exactly one cycle, and return to IDLE.
REQ-019 SHALL give these latencies: obusy high for 33 cycles after t0; odone visible in the cycle after t33; outputs change only at t33.
REQ-020 SHALL accept the earliest next request at t34; istart held high continuously yields one conversion every 34 cycles.
REQ-021 SHALL hold ofrq_bcd/ovpp_bcd stable between DONE edges; the outputs are never partially updated.
REQ-022 SHALL, when BLANK_LZ=1, replace every zero digit above the most significant non-zero digit by 4'hF, with digit 0 never blanked, applied at the DONE load.
REQ-023 SHALL cover the full 16-bit range (max 65535 -> 20'h65535) with no overflow condition.
REQ-024 SHALL have an implementation of a shared single converter datapath (one 20-bit BCD + 16-bit shift register, a 5-bit step counter), not duplicated per channel.

Reset
REQ-025 SHALL, on irst=1 at an edge, force state IDLE, obusy=0, odone=0, ofrq_bcd=0, ovpp_bcd=0, and clear the internal counter and scratch registers.
REQ-026 SHALL abort a conversion on reset mid-operation: no odone and no output update follow; outputs read 0 until a later full conversion.
REQ-027 SHALL give irst priority over istart on the same edge; istart is not accepted.
REQ-028 SHALL honor istart from the first edge with irst=0.

Verification
REQ-029 SHALL verify basic conversion: reset, then ifrq=1234, ivpp=3300, istart 1 cycle -> obusy for 33 cycles, single odone, ofrq_bcd=20'h01234, ovpp_bcd=20'h03300.
REQ-030 SHALL verify range bounds: ifrq=65535, ivpp=0 -> ofrq_bcd=20'h65535, ovpp_bcd=20'h00000; with BLANK_LZ=1, ifrq=7, ivpp=0 -> 20'hFFFF7, 20'hFFFF0.
REQ-031 SHALL verify busy behaviour: istart pulse at t5 while busy plus ifrq changed 1234->999 at t3 -> results still 01234, exactly one odone, no second conversion.
REQ-032 SHALL verify reset abort: irst at t10 of a conversion -> obusy=0 next cycle, outputs 0, no odone within the following 40 cycles.
REQ-033 SHALL verify continuous requests: istart held high, ifrq incremented after each odone -> odone period exactly 34 cycles and each result matches the value latched at its accept edge.
